// File: rtl/hopfield_pkg.sv
// Shared defaults and FSM state type for the Hopfield spike-pattern readout.
package hopfield_pkg;
    localparam int unsigned N_DEF     = 7;
    localparam int unsigned CNT_W_DEF = 11;
    localparam int unsigned IDX_W_DEF = 3;

    typedef enum logic [1:0] {IDLE, ACCUM, LATCH} state_t;
endpackage

// File: rtl/spike_pattern_decoder_if.sv
// Result port of the spike pattern decoder: valid/ready handshake plus window result fields.
interface spike_pattern_decoder_if
    import hopfield_pkg::*;
#(
    parameter int unsigned N     = N_DEF,
    parameter int unsigned CNT_W = CNT_W_DEF,
    parameter int unsigned IDX_W = IDX_W_DEF
);
    logic             out_valid;
    logic             out_ready;
    logic [N-1:0]     out_pattern;
    logic [IDX_W-1:0] out_winner;
    logic [CNT_W-1:0] out_winner_count;
    logic             converged;
    logic             overrun;

    modport master (
        output out_valid, out_pattern, out_winner, out_winner_count, converged, overrun,
        input  out_ready
    );

    modport slave (
        input  out_valid, out_pattern, out_winner, out_winner_count, converged, overrun,
        output out_ready
    );
endinterface

// File: rtl/spike_pattern_decoder_rate_counter.sv
// Per-neuron rising-edge detector feeding a saturating spike counter.
module spike_rate_counter #(
    parameter int unsigned CNT_W = 11
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    input  logic             en,
    input  logic             spike,
    output logic [CNT_W-1:0] count
);
    logic prev;

    // prev tracks the input every cycle so a level held across window boundaries counts once
    always_ff @(posedge clk) begin
        if (reset) begin
            prev  <= 1'b0;
            count <= '0;
        end else begin
            prev <= spike;
            if (clr) begin
                count <= '0;
            end else if (en && spike && !prev && (count != '1)) begin
                count <= count + CNT_W'(1);
            end
        end
    end
endmodule

// File: rtl/spike_pattern_decoder.sv
// Windowed rate decoder: counts spikes, thresholds into a pattern, picks the winner, tracks convergence.
module spike_pattern_decoder
    import hopfield_pkg::*;
#(
    parameter int unsigned N      = N_DEF,
    parameter int unsigned WINDOW = 1024,
    parameter int unsigned CNT_W  = CNT_W_DEF,
    parameter int unsigned THRESH = 8,
    parameter int unsigned STABLE = 3,
    parameter int unsigned IDX_W  = IDX_W_DEF
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    run,
    input  logic [N-1:0]            spikes,
    spike_pattern_decoder_if.master result
);
    localparam int unsigned WCNT_W = $clog2(WINDOW);
    localparam int unsigned STAB_W = $clog2(STABLE + 1);
    localparam logic [WCNT_W-1:0] WIN_LAST = WCNT_W'(WINDOW - 1);

    state_t            state, state_next;
    logic [WCNT_W-1:0] wcnt, wcnt_next;
    logic              clr, en, start, latch;

    logic [CNT_W-1:0]  counts [N];
    logic [N-1:0]      pattern;
    logic [IDX_W-1:0]  best_idx;
    logic [CNT_W-1:0]  best_cnt;

    logic [STAB_W-1:0] stab_cnt, stab_inc, stab_next;
    logic              have_prev;

    for (genvar g = 0; g < N; g++) begin : g_cnt
        spike_rate_counter #(.CNT_W(CNT_W)) u_cnt (
            .clk   (clk),
            .reset (reset),
            .clr   (clr),
            .en    (en),
            .spike (spikes[g]),
            .count (counts[g])
        );
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            wcnt  <= '0;
        end else begin
            state <= state_next;
            wcnt  <= wcnt_next;
        end
    end

    always_comb begin
        state_next = state;
        wcnt_next  = wcnt;
        clr        = 1'b0;
        en         = 1'b0;
        start      = 1'b0;
        latch      = 1'b0;
        unique case (state)
            IDLE: begin
                if (run) begin
                    state_next = ACCUM;
                    wcnt_next  = '0;
                    clr        = 1'b1;
                    start      = 1'b1;
                end
            end
            ACCUM: begin
                if (!run) begin
                    state_next = IDLE;
                end else begin
                    en = 1'b1;
                    if (wcnt == WIN_LAST) state_next = LATCH;
                    else                  wcnt_next  = wcnt + WCNT_W'(1);
                end
            end
            LATCH: begin
                latch      = 1'b1;
                clr        = 1'b1;
                wcnt_next  = '0;
                state_next = run ? ACCUM : IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // strict '>' keeps the lowest index on ties
    always_comb begin
        pattern  = '0;
        best_idx = '0;
        best_cnt = counts[0];
        for (int unsigned i = 0; i < N; i++) begin
            pattern[i] = (32'(counts[i]) >= THRESH);
            if (counts[i] > best_cnt) begin
                best_cnt = counts[i];
                best_idx = IDX_W'(i);
            end
        end
    end

    always_comb begin
        stab_inc  = stab_cnt;
        if (32'(stab_cnt) < STABLE) stab_inc = stab_cnt + STAB_W'(1);
        stab_next = (have_prev && (pattern == result.out_pattern)) ? stab_inc : STAB_W'(1);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            result.out_valid        <= 1'b0;
            result.out_pattern      <= '0;
            result.out_winner       <= '0;
            result.out_winner_count <= '0;
            result.converged        <= 1'b0;
            result.overrun          <= 1'b0;
            stab_cnt                <= '0;
            have_prev               <= 1'b0;
        end else begin
            if (start) begin
                result.overrun   <= 1'b0;
                result.converged <= 1'b0;
                stab_cnt         <= '0;
                have_prev        <= 1'b0;
            end
            // a new result takes priority over a same-cycle handshake
            if (latch) begin
                result.out_pattern      <= pattern;
                result.out_winner       <= best_idx;
                result.out_winner_count <= best_cnt;
                result.converged        <= (32'(stab_next) >= STABLE);
                result.out_valid        <= 1'b1;
                stab_cnt                <= stab_next;
                have_prev               <= 1'b1;
                if (result.out_valid && !result.out_ready) result.overrun <= 1'b1;
            end else if (result.out_valid && result.out_ready) begin
                result.out_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_spike_pattern_decoder.sv
// Bench for spike_pattern_decoder: two instances (CNT_W 5 and 3) against a window-level reference model.
module tb_spike_pattern_decoder;
    localparam int unsigned N      = 7;
    localparam int unsigned WINDOW = 16;
    localparam int unsigned THRESH = 4;
    localparam int unsigned STABLE = 3;
    localparam int unsigned IDX_W  = 3;
    localparam int unsigned CW_A   = 5;
    localparam int unsigned CW_B   = 3;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         run = 1'b0;
    logic         ready = 1'b0;
    logic [N-1:0] spikes = '0;

    int unsigned vectors = 0;
    int unsigned miscompares = 0;

    spike_pattern_decoder_if #(.N(N), .CNT_W(CW_A), .IDX_W(IDX_W)) bus_a ();
    spike_pattern_decoder_if #(.N(N), .CNT_W(CW_B), .IDX_W(IDX_W)) bus_b ();
    assign bus_a.out_ready = ready;
    assign bus_b.out_ready = ready;

    spike_pattern_decoder #(
        .N(N), .WINDOW(WINDOW), .CNT_W(CW_A), .THRESH(THRESH), .STABLE(STABLE), .IDX_W(IDX_W)
    ) dut_a (
        .clk(clk), .reset(reset), .run(run), .spikes(spikes), .result(bus_a.master)
    );

    spike_pattern_decoder #(
        .N(N), .WINDOW(WINDOW), .CNT_W(CW_B), .THRESH(THRESH), .STABLE(STABLE), .IDX_W(IDX_W)
    ) dut_b (
        .clk(clk), .reset(reset), .run(run), .spikes(spikes), .result(bus_b.master)
    );

    always #5 clk = ~clk;

    // Reference model: phase -1 = not decoding, 0..WINDOW-1 = cycles accumulated, WINDOW = result cycle
    int           phase = -1;
    logic [N-1:0] m_prev = '0;
    int           m_cnt [N];
    logic         m_valid = 1'b0, m_ovr = 1'b0, m_conv = 1'b0;
    logic [N-1:0] m_pat = '0;
    int           m_win [2];
    int           m_wc [2];
    logic [N-1:0] hist [$];

    function automatic int sat(input int c, input int unsigned w);
        int top = (1 << w) - 1;
        return (c > top) ? top : c;
    endfunction

    task automatic publish();
        m_pat = '0;
        for (int i = 0; i < int'(N); i++) m_pat[i] = (m_cnt[i] >= int'(THRESH));
        for (int d = 0; d < 2; d++) begin
            int unsigned w = (d == 0) ? CW_A : CW_B;
            m_win[d] = 0;
            m_wc[d]  = sat(m_cnt[0], w);
            for (int i = 1; i < int'(N); i++) begin
                if (sat(m_cnt[i], w) > m_wc[d]) begin
                    m_wc[d]  = sat(m_cnt[i], w);
                    m_win[d] = i;
                end
            end
        end
        hist.push_back(m_pat);
        m_conv = 1'b0;
        if (hist.size() >= int'(STABLE)) begin
            m_conv = 1'b1;
            for (int k = 1; k < int'(STABLE); k++)
                if (hist[hist.size() - 1 - k] != hist[hist.size() - 1]) m_conv = 1'b0;
        end
    endtask

    task automatic model_step();
        logic hs;
        hs = m_valid && ready;
        if (reset) begin
            phase = -1; m_prev = '0; m_valid = 1'b0; m_ovr = 1'b0; m_conv = 1'b0; m_pat = '0;
            for (int i = 0; i < int'(N); i++) m_cnt[i] = 0;
            for (int d = 0; d < 2; d++) begin m_win[d] = 0; m_wc[d] = 0; end
            hist.delete();
        end else begin
            if (phase < 0) begin
                if (run) begin
                    phase = 0; m_ovr = 1'b0; m_conv = 1'b0; hist.delete();
                    for (int i = 0; i < int'(N); i++) m_cnt[i] = 0;
                end
                if (hs) m_valid = 1'b0;
            end else if (phase < int'(WINDOW)) begin
                if (!run) phase = -1;
                else begin
                    for (int i = 0; i < int'(N); i++) if (spikes[i] && !m_prev[i]) m_cnt[i]++;
                    phase++;
                end
                if (hs) m_valid = 1'b0;
            end else begin
                publish();
                if (m_valid && !ready) m_ovr = 1'b1;
                m_valid = 1'b1;
                for (int i = 0; i < int'(N); i++) m_cnt[i] = 0;
                phase = run ? 0 : -1;
            end
            m_prev = spikes;
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic compare_all();
        check("valid_a",   32'(bus_a.out_valid),        32'(m_valid));
        check("pattern_a", 32'(bus_a.out_pattern),      32'(m_pat));
        check("winner_a",  32'(bus_a.out_winner),       32'(m_win[0]));
        check("wcount_a",  32'(bus_a.out_winner_count), 32'(m_wc[0]));
        check("conv_a",    32'(bus_a.converged),        32'(m_conv));
        check("overrun_a", 32'(bus_a.overrun),          32'(m_ovr));
        check("valid_b",   32'(bus_b.out_valid),        32'(m_valid));
        check("pattern_b", 32'(bus_b.out_pattern),      32'(m_pat));
        check("winner_b",  32'(bus_b.out_winner),       32'(m_win[1]));
        check("wcount_b",  32'(bus_b.out_winner_count), 32'(m_wc[1]));
        check("conv_b",    32'(bus_b.converged),        32'(m_conv));
        check("overrun_b", 32'(bus_b.overrun),          32'(m_ovr));
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        compare_all();
    endtask

    // leave any window via IDLE, then begin a fresh aligned window
    task automatic start_window();
        spikes = '0;
        run = 1'b0;
        tick();
        tick();
        run = 1'b1;
        tick();
    endtask

    initial begin
        for (int i = 0; i < int'(N); i++) m_cnt[i] = 0;
        for (int d = 0; d < 2; d++) begin m_win[d] = 0; m_wc[d] = 0; end

        // reset held with run high and toggling spikes
        reset = 1'b1; run = 1'b1; ready = 1'b1;
        for (int c = 0; c < 3; c++) begin
            spikes = N'($urandom);
            tick();
        end
        reset = 1'b0;

        // single neuron pulsing every other cycle, five windows
        for (int c = 0; c < 1 + 5 * int'(WINDOW + 1); c++) begin
            spikes = (c % 2 == 1) ? 7'b0000100 : 7'b0000000;
            tick();
        end
        check("t2_pattern", 32'(bus_a.out_pattern), 32'h04);
        check("t2_winner",  32'(bus_a.out_winner), 32'd2);
        check("t2_count_a", 32'(bus_a.out_winner_count), 32'd8);
        check("t2_count_b", 32'(bus_b.out_winner_count), 32'd7);
        check("t2_conv",    32'(bus_a.converged), 32'd1);

        // held level counts once; neuron 4 pulses five times
        start_window();
        for (int c = 0; c < int'(WINDOW); c++) begin
            spikes = '0;
            spikes[0] = (c < 10);
            spikes[4] = (c < 10) && (c % 2 == 0);
            tick();
        end
        spikes = '0;
        tick();
        check("t3_pattern", 32'(bus_a.out_pattern), 32'h10);
        check("t3_winner",  32'(bus_a.out_winner), 32'd4);
        check("t3_count",   32'(bus_a.out_winner_count), 32'd5);
        check("t3_valid",   32'(bus_a.out_valid), 32'd1);

        // tie between neurons 1 and 5, then a saturating window
        start_window();
        for (int c = 0; c < int'(WINDOW); c++) begin
            spikes = ((c < 12) && (c % 2 == 0)) ? 7'b0100010 : 7'b0000000;
            tick();
        end
        spikes = '0;
        tick();
        check("t4_pattern", 32'(bus_a.out_pattern), 32'h22);
        check("t4_winner",  32'(bus_a.out_winner), 32'd1);
        check("t4_count",   32'(bus_a.out_winner_count), 32'd6);
        for (int c = 0; c < int'(WINDOW); c++) begin
            spikes = (c % 2 == 0) ? 7'b0100010 : 7'b0000000;
            tick();
        end
        spikes = '0;
        tick();
        check("t4_sat_count_a", 32'(bus_a.out_winner_count), 32'd8);
        check("t4_sat_count_b", 32'(bus_b.out_winner_count), 32'd7);
        check("t4_sat_winner",  32'(bus_b.out_winner), 32'd1);

        // two unconsumed results in a row
        ready = 1'b0;
        start_window();
        for (int w = 0; w < 2; w++) begin
            for (int c = 0; c < int'(WINDOW); c++) begin
                spikes = (c % 2 == 0) ? ((w == 0) ? 7'b0001000 : 7'b1000000) : 7'b0000000;
                tick();
            end
            spikes = '0;
            tick();
        end
        check("t5_valid",   32'(bus_a.out_valid), 32'd1);
        check("t5_pattern", 32'(bus_a.out_pattern), 32'h40);
        check("t5_overrun", 32'(bus_a.overrun), 32'd1);
        for (int c = 0; c < 7; c++) tick();
        ready = 1'b1;
        tick();
        ready = 1'b0;
        tick();
        check("t5_drop_valid",  32'(bus_a.out_valid), 32'd0);
        check("t5_sticky_ovr",  32'(bus_a.overrun), 32'd1);

        // abort mid-window, then restart
        run = 1'b0;
        tick();
        tick();
        check("t6_abort_valid", 32'(bus_a.out_valid), 32'd0);
        run = 1'b1;
        tick();
        check("t6_restart_ovr",  32'(bus_a.overrun), 32'd0);
        check("t6_restart_conv", 32'(bus_a.converged), 32'd0);
        ready = 1'b1;
        for (int c = 0; c < int'(WINDOW) + 1; c++) begin
            spikes = N'($urandom);
            tick();
        end
        check("t6_result_valid", 32'(bus_a.out_valid), 32'd1);

        // reset in the middle of a window
        for (int c = 0; c < 5; c++) begin
            spikes = N'($urandom);
            tick();
        end
        reset = 1'b1;
        tick();
        check("t6_rst_valid",   32'(bus_a.out_valid), 32'd0);
        check("t6_rst_pattern", 32'(bus_a.out_pattern), 32'd0);
        reset = 1'b0;

        // randomized traffic with random back-pressure and occasional aborts
        for (int c = 0; c < 400; c++) begin
            spikes = N'($urandom) & N'($urandom);
            ready  = ($urandom_range(0, 3) != 0);
            run    = ($urandom_range(0, 79) != 0);
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
